mem_responder: RTL and testbench

Synchronous 64-entry x 8-bit memory target that answers the addr/en/wr bus driven by the team's stimulus tasks. Sits on the 25 MHz (40 ns) bench/DUT clock as the responder end of that bus. Accepts one request per cycle, commits writes, returns read data with fixed one-cycle latency, and enforces a write-protected upper region. Keeps saturating access counters for scoreboard cross-checks.

---
 rtl/mem_responder.sv | 83 ++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// 64 x 8 memory target with one-cycle registered responses, a write-protected
// upper region, and saturating write/read access counters.
module mem_responder #(
  parameter logic [5:0]  PROT_BASE = 6'h38,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [5:0]       addr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             rvalid,
  output logic             ack,
  output logic             err,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);

  logic [7:0]       mem_q [64];
  logic [7:0]       dout_q, dout_d;
  logic             rvalid_q, rvalid_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             do_wr, do_rd, do_err;

  // en gates every decode term so X on wr/addr/din while idle stays harmless
  always_comb begin
    do_wr    = en && wr && (addr < PROT_BASE);
    do_err   = en && wr && (addr >= PROT_BASE);
    do_rd    = en && !wr;
    rvalid_d = do_rd;
    ack_d    = do_wr;
    err_d    = do_err;
    dout_d   = dout_q;
    if (do_rd) begin
      dout_d = mem_q[addr];
    end
    wr_cnt_d = wr_cnt_q;
    if (do_wr && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    rd_cnt_d = rd_cnt_q;
    if (do_rd && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 64; i++) begin
        mem_q[i] <= '0;
      end
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (do_wr) begin
        mem_q[addr] <= din;
      end
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign dout     = dout_q;
  assign rvalid   = rvalid_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a reference model pushes the expected
// response per request; each test task pops and compares it one cycle later.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst, en, wr;
  logic [5:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout, s_dout;
  logic        rvalid, ack, err, s_rvalid, s_ack, s_err;
  logic [15:0] wr_count, rd_count;
  logic [3:0]  s_wr_count, s_rd_count;

  typedef struct packed {
    logic       rv;
    logic       ak;
    logic       er;
    logic [7:0] d;
  } resp_t;

  resp_t       sb[$];
  resp_t       r;
  logic [7:0]  mdl_mem [64];
  logic [7:0]  mdl_dout;
  int unsigned mdl_wr, mdl_rd, mdl_rd4;
  int          checks = 0;
  int          errors = 0;

  always #20 clk = ~clk;

  mem_responder #(.PROT_BASE(6'h38), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .din(din),
    .dout(dout), .rvalid(rvalid), .ack(ack), .err(err),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  mem_responder #(.PROT_BASE(6'h38), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .din(din),
    .dout(s_dout), .rvalid(s_rvalid), .ack(s_ack), .err(s_err),
    .wr_count(s_wr_count), .rd_count(s_rd_count)
  );

  // Drive one request at a negedge, update the model, advance past the edge.
  task automatic drive(input logic r_, input logic e, input logic w,
                       input logic [5:0] a, input logic [7:0] d);
    rst = r_; en = e; wr = w; addr = a; din = d;
    if (r_ === 1'b1) begin
      for (int i = 0; i < 64; i++) mdl_mem[i] = 8'h00;
      mdl_dout = 8'h00; mdl_wr = 0; mdl_rd = 0; mdl_rd4 = 0;
      sb.push_back('{1'b0, 1'b0, 1'b0, 8'h00});
    end else if (e === 1'b1 && w === 1'b1) begin
      if (a < 6'h38) begin
        mdl_mem[a] = d;
        if (mdl_wr < 16'hFFFF) mdl_wr++;
        sb.push_back('{1'b0, 1'b1, 1'b0, mdl_dout});
      end else begin
        sb.push_back('{1'b0, 1'b0, 1'b1, mdl_dout});
      end
    end else if (e === 1'b1) begin
      mdl_dout = mdl_mem[a];
      if (mdl_rd < 16'hFFFF) mdl_rd++;
      if (mdl_rd4 < 15) mdl_rd4++;
      sb.push_back('{1'b1, 1'b0, 1'b0, mdl_dout});
    end else begin
      sb.push_back('{1'b0, 1'b0, 1'b0, mdl_dout});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 6'h05, 8'hEE);
    sb.delete();
    checks++;
    if ({rvalid, ack, err, dout} !== 11'h000) begin
      errors++;
      $display("FAIL reset_resp got=%h exp=000", {rvalid, ack, err, dout});
    end
    checks++;
    if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts got wr=%0d rd=%0d exp 0/0", wr_count, rd_count);
    end
  endtask

  task automatic test_write_burst();
    logic [5:0] a [2] = '{6'h12, 6'h14};
    logic [7:0] d [2] = '{8'hA5, 8'h3C};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, a[i], d[i]);
      r = sb.pop_front();
      checks++;
      if ({rvalid, ack, err, dout} !== r || ack !== 1'b1) begin
        errors++;
        $display("FAIL burst[%0d] got=%h exp=%h", i, {rvalid, ack, err, dout}, r);
      end
    end
    checks++;
    if (wr_count !== 16'd2) begin
      errors++;
      $display("FAIL burst_wr_count got=%0d exp=2", wr_count);
    end
  endtask

  task automatic test_read_back();
    logic [5:0] a [3] = '{6'h12, 6'h14, 6'h23};
    logic [7:0] d [3] = '{8'hA5, 8'h3C, 8'h00};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, a[i], 8'h00);
      r = sb.pop_front();
      checks++;
      if ({rvalid, ack, err, dout} !== r || dout !== d[i] || rvalid !== 1'b1) begin
        errors++;
        $display("FAIL readback[%0d] got=%h exp=%h data=%h", i, {rvalid, ack, err, dout}, r, d[i]);
      end
    end
    checks++;
    if (rd_count !== 16'd3) begin
      errors++;
      $display("FAIL readback_rd_count got=%0d exp=3", rd_count);
    end
  endtask

  task automatic test_write_protect();
    logic       w [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] a [3] = '{6'h38, 6'h3F, 6'h38};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, w[i], a[i], 8'hFF);
      r = sb.pop_front();
      checks++;
      if ({rvalid, ack, err, dout} !== r || ack !== 1'b0) begin
        errors++;
        $display("FAIL protect[%0d] got=%h exp=%h", i, {rvalid, ack, err, dout}, r);
      end
    end
    checks++;
    if (dout !== 8'h00 || wr_count !== 16'd2) begin
      errors++;
      $display("FAIL protect_state got dout=%h wr=%0d exp 00/2", dout, wr_count);
    end
  endtask

  task automatic test_raw_idle();
    drive(1'b0, 1'b1, 1'b1, 6'h16, 8'h5A);
    r = sb.pop_front();
    checks++;
    if ({rvalid, ack, err, dout} !== r) begin
      errors++;
      $display("FAIL raw_write got=%h exp=%h", {rvalid, ack, err, dout}, r);
    end
    drive(1'b0, 1'b1, 1'b0, 6'h16, 8'h00);
    r = sb.pop_front();
    checks++;
    if ({rvalid, ack, err, dout} !== r || dout !== 8'h5A) begin
      errors++;
      $display("FAIL raw_read got=%h exp=%h", {rvalid, ack, err, dout}, r);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b0, 1'b0, 1'bx, 6'bx, 8'bx);
      else drive(1'b0, 1'b0, 1'($urandom), 6'($urandom), 8'($urandom));
      r = sb.pop_front();
      checks++;
      if ({rvalid, ack, err, dout} !== r || dout !== 8'h5A) begin
        errors++;
        $display("FAIL idle[%0d] got=%h exp=%h", i, {rvalid, ack, err, dout}, r);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 6'h16, 8'h00);
    r = sb.pop_front();
    checks++;
    if (dout !== r.d || dout !== 8'h5A) begin
      errors++;
      $display("FAIL idle_no_corrupt got=%h exp=5a", dout);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b1, 6'h01, 8'h77);
    r = sb.pop_front();
    checks++;
    if ({rvalid, ack, err, dout} !== r) begin
      errors++;
      $display("FAIL rstmid_write got=%h exp=%h", {rvalid, ack, err, dout}, r);
    end
    drive(1'b1, 1'b1, 1'b0, 6'h01, 8'h00);
    r = sb.pop_front();
    checks++;
    if ({rvalid, ack, err, dout} !== r || wr_count !== 16'd0 || rd_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_reset got=%h wr=%0d rd=%0d exp=%h 0/0",
               {rvalid, ack, err, dout}, wr_count, rd_count, r);
    end
    drive(1'b0, 1'b1, 1'b0, 6'h01, 8'h00);
    r = sb.pop_front();
    checks++;
    if ({rvalid, ack, err, dout} !== r || dout !== 8'h00 || rd_count !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_read got=%h rd=%0d exp=%h 1", {rvalid, ack, err, dout}, rd_count, r);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    sb.delete();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 6'($urandom_range(0, 63)), 8'h00);
      r = sb.pop_front();
      checks++;
      if (s_rvalid !== 1'b1 || {s_rvalid, s_ack, s_err, s_dout} !== r ||
          s_rd_count !== 4'(mdl_rd4)) begin
        errors++;
        $display("FAIL sat[%0d] got=%h cnt=%0d exp=%h cnt=%0d",
                 i, {s_rvalid, s_ack, s_err, s_dout}, s_rd_count, r, mdl_rd4);
      end
    end
    checks++;
    if (s_rd_count !== 4'hF || rd_count !== 16'd20) begin
      errors++;
      $display("FAIL sat_final got cnt4=%h cnt16=%0d exp f/20", s_rd_count, rd_count);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
    @(negedge clk);
    test_reset();
    test_write_burst();
    test_read_back();
    test_write_protect();
    test_raw_idle();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
